// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter
//   Shares one synchronous single-port sprite ROM between several pixel-pipeline
//   requesters (background, tank sprites, bullets) on the VGA clock domain.
//   One request is granted per cycle by round-robin. Each read carries a
//   one-hot tag down a ROM_LAT-deep pipeline so that the returned ROM word is
//   steered back to the requester that issued it.
//
// Ports
//   vga_clk_i      pixel clock, all state on the rising edge
//   reset_n_i      synchronous active-low reset
//   req_i          per-requester read request, held until granted
//   req_addr_i     packed request addresses, requester i at [i*ADDR_W +: ADDR_W]
//   gnt_o          one-hot grant, combinational from req_i and the rr pointer
//   rom_address_o  address of the granted requester, 0 when nothing is granted
//   rom_q_i        ROM read data, valid ROM_LAT cycles after the address edge
//   rd_data_o      registered returned ROM word
//   rd_valid_o     registered one-hot owner of rd_data_o
//   busy_o         high while any read is still in flight
module sprite_rom_arbiter #(
  parameter int N_REQ   = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int ROM_LAT = 1
) (
  input  logic                      vga_clk_i,
  input  logic                      reset_n_i,
  input  logic [N_REQ-1:0]          req_i,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr_i,
  output logic [N_REQ-1:0]          gnt_o,
  output logic [ADDR_W-1:0]         rom_address_o,
  input  logic [DATA_W-1:0]         rom_q_i,
  output logic [DATA_W-1:0]         rd_data_o,
  output logic [N_REQ-1:0]          rd_valid_o,
  output logic                      busy_o
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int TAG_W = N_REQ + 1;  // {valid, one-hot owner}

  logic [PTR_W-1:0]              rr_ptr_q;
  logic [PTR_W-1:0]              rr_ptr_d;
  logic [N_REQ-1:0]              gnt_s;
  logic [PTR_W-1:0]              gnt_idx_s;
  logic                          gnt_any_s;
  logic                          found_s;
  logic [PTR_W:0]                sum_s;
  logic [PTR_W-1:0]              idx_s;
  logic [ADDR_W-1:0]             rom_addr_s;
  logic [ROM_LAT-1:0][TAG_W-1:0] tag_q;
  logic [ROM_LAT-1:0][TAG_W-1:0] tag_d;
  logic [N_REQ-1:0]              rd_valid_q;
  logic [N_REQ-1:0]              rd_valid_d;
  logic [DATA_W-1:0]             rd_data_q;
  logic                          pipe_busy_s;

  // Round-robin search from rr_ptr upward with wrap; grants are suppressed in reset.
  always_comb begin
    gnt_s     = '0;
    gnt_idx_s = '0;
    found_s   = 1'b0;
    sum_s     = '0;
    idx_s     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      // The sum is one bit wider so the wrap works for non power-of-two N_REQ.
      sum_s = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (sum_s >= (PTR_W+1)'(N_REQ)) begin
        sum_s = sum_s - (PTR_W+1)'(N_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[PTR_W-1:0];
      if (reset_n_i && !found_s && req_i[idx_s]) begin
        gnt_s[idx_s] = 1'b1;
        gnt_idx_s    = idx_s;
        found_s      = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
    gnt_any_s = found_s;
  end

  // Pointer moves just past the granted requester; holds when idle.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (gnt_any_s) begin
      rr_ptr_d = (gnt_idx_s == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // One-hot AND-OR address mux; yields 0 when nothing is granted.
  always_comb begin
    rom_addr_s = '0;
    for (int i = 0; i < N_REQ; i++) begin
      rom_addr_s = rom_addr_s | (req_addr_i[i*ADDR_W +: ADDR_W] & {ADDR_W{gnt_s[i]}});
    end
  end

  // Tag pipeline shift, returning-owner decode and in-flight detection.
  always_comb begin
    tag_d       = '0;
    pipe_busy_s = 1'b0;
    tag_d[0]    = {gnt_any_s, gnt_s};
    for (int s = 1; s < ROM_LAT; s++) begin
      tag_d[s] = tag_q[s-1];
    end
    for (int s = 0; s < ROM_LAT; s++) begin
      pipe_busy_s = pipe_busy_s | tag_q[s][N_REQ];
    end
    // The last stage lines up with rom_q_i.
    if (tag_q[ROM_LAT-1][N_REQ]) begin
      rd_valid_d = tag_q[ROM_LAT-1][N_REQ-1:0];
    end else begin
      rd_valid_d = '0;
    end
  end

  // State registers; reset also drops any reads still in the pipe.
  always_ff @(posedge vga_clk_i) begin
    if (!reset_n_i) begin
      rr_ptr_q   <= '0;
      tag_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      tag_q      <= tag_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rom_q_i;
    end
  end

  assign gnt_o         = gnt_s;
  assign rom_address_o = rom_addr_s;
  assign rd_data_o     = rd_data_q;
  assign rd_valid_o    = rd_valid_q;
  assign busy_o        = pipe_busy_s | (|rd_valid_q);

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
module tb_sprite_rom_arbiter;

  typedef struct {
    int         due;
    logic [3:0] tag;
    logic [7:0] data;
  } sb_t;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req;
  logic [39:0] addr;

  logic [3:0]  o_gnt  [2];
  logic [9:0]  o_addr [2];
  logic [7:0]  o_rdd  [2];
  logic [3:0]  o_rdv  [2];
  logic        o_busy [2];

  // ROM models: q = address[7:0], latency 1 and 3.
  logic [7:0] rom1_q  = 8'h00;
  logic [7:0] rom3_s0 = 8'h00;
  logic [7:0] rom3_s1 = 8'h00;
  logic [7:0] rom3_q  = 8'h00;

  sb_t  sbq [2][$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   rr_m  = 0;

  logic [3:0] s_gnt;
  logic [9:0] s_addr;
  logic [3:0] s_rdv;
  logic [7:0] s_rdd;
  logic       s_busy;

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(8), .ROM_LAT(1)) dut1 (
    .vga_clk_i(clk), .reset_n_i(reset_n), .req_i(req), .req_addr_i(addr),
    .gnt_o(o_gnt[0]), .rom_address_o(o_addr[0]), .rom_q_i(rom1_q),
    .rd_data_o(o_rdd[0]), .rd_valid_o(o_rdv[0]), .busy_o(o_busy[0])
  );

  sprite_rom_arbiter #(.N_REQ(4), .ADDR_W(10), .DATA_W(8), .ROM_LAT(3)) dut3 (
    .vga_clk_i(clk), .reset_n_i(reset_n), .req_i(req), .req_addr_i(addr),
    .gnt_o(o_gnt[1]), .rom_address_o(o_addr[1]), .rom_q_i(rom3_q),
    .rd_data_o(o_rdd[1]), .rd_valid_o(o_rdv[1]), .busy_o(o_busy[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    rom1_q  <= o_addr[0][7:0];
    rom3_s0 <= o_addr[1][7:0];
    rom3_s1 <= rom3_s0;
    rom3_q  <= rom3_s1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: sample at negedge, check against model, advance.
  task automatic step();
    logic [3:0] eg;
    logic [9:0] ea;
    int         ei;
    int         idx;
    int         lat;
    @(negedge clk);
    eg = 4'b0000;
    ea = 10'h000;
    ei = 0;
    if (reset_n) begin
      for (int k = 0; k < 4; k++) begin
        idx = (rr_m + k) % 4;
        if (eg == 4'b0000 && req[idx]) begin
          eg[idx] = 1'b1;
          ei      = idx;
        end
      end
    end
    if (eg != 4'b0000) ea = addr[ei*10 +: 10];
    s_gnt  = o_gnt[0];
    s_addr = o_addr[0];
    s_rdv  = o_rdv[0];
    s_rdd  = o_rdd[0];
    s_busy = o_busy[0];
    if (cyc > 0) begin
      for (int d = 0; d < 2; d++) begin
        lat = (d == 0) ? 1 : 3;
        chk($sformatf("gnt_lat%0d", lat), 32'(o_gnt[d]), 32'(eg));
        chk($sformatf("rom_address_lat%0d", lat), 32'(o_addr[d]), 32'(ea));
        chk($sformatf("busy_lat%0d", lat), 32'(o_busy[d]), 32'(sbq[d].size() != 0));
        if (sbq[d].size() > 0 && sbq[d][0].due == cyc) begin
          chk($sformatf("rd_valid_lat%0d", lat), 32'(o_rdv[d]), 32'(sbq[d][0].tag));
          chk($sformatf("rd_data_lat%0d", lat), 32'(o_rdd[d]), 32'(sbq[d][0].data));
          void'(sbq[d].pop_front());
        end else begin
          chk($sformatf("rd_valid_idle_lat%0d", lat), 32'(o_rdv[d]), 32'h0);
        end
      end
    end
    if (!reset_n) begin
      sbq[0].delete();
      sbq[1].delete();
      rr_m = 0;
    end else if (eg != 4'b0000) begin
      sbq[0].push_back('{due: cyc + 2, tag: eg, data: ea[7:0]});
      sbq[1].push_back('{due: cyc + 4, tag: eg, data: ea[7:0]});
      rr_m = (ei + 1) % 4;
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle(input int n);
    req = 4'b0000;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [3:0]  rr_seq [8];
  logic [63:0] rnd;

  initial begin
    reset_n = 1'b0;
    req     = 4'b0000;
    addr    = 40'h0;

    // Reset then idle
    step();
    step();
    chk("reset_gnt", 32'(s_gnt), 32'h0);
    chk("reset_rom_address", 32'(s_addr), 32'h0);
    chk("reset_rd_valid", 32'(s_rdv), 32'h0);
    chk("reset_rd_data", 32'(s_rdd), 32'h0);
    chk("reset_busy", 32'(s_busy), 32'h0);
    reset_n = 1'b1;
    idle(10);
    chk("idle_rd_data", 32'(s_rdd), 32'h0);
    chk("idle_busy", 32'(s_busy), 32'h0);

    // Single read from requester 2
    req  = 4'b0100;
    addr = {10'h000, 10'h155, 10'h000, 10'h000};
    step();
    chk("single_gnt", 32'(s_gnt), 32'h4);
    chk("single_rom_address", 32'(s_addr), 32'h155);
    req = 4'b0000;
    step();
    chk("single_busy_t1", 32'(s_busy), 32'h1);
    step();
    chk("single_rd_valid", 32'(s_rdv), 32'h4);
    chk("single_rd_data", 32'(s_rdd), 32'h55);
    chk("single_busy_t2", 32'(s_busy), 32'h1);
    idle(4);

    // Round-robin wrap from reset
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rr_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    req  = 4'b1111;
    addr = {10'h040, 10'h030, 10'h020, 10'h010};
    for (int i = 0; i < 8; i++) begin
      step();
      chk($sformatf("rr_wrap_%0d", i), 32'(s_gnt), 32'(rr_seq[i]));
    end
    idle(5);

    // Fairness with skipped requesters, then lone requester 3 after its grant
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    rr_seq = '{4'b0001, 4'b1000, 4'b0001, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
    req  = 4'b1001;
    addr = {10'h0A3, 10'h0B2, 10'h0C1, 10'h0D0};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("fair_%0d", i), 32'(s_gnt), 32'(rr_seq[i]));
    end
    req = 4'b1000;
    step();
    chk("fair_wrap_to_3", 32'(s_gnt), 32'h8);
    idle(5);

    // Reset mid-operation discards in-flight reads
    req  = 4'b0001;
    addr = {10'h3FF, 10'h2EE, 10'h1DD, 10'h0CC};
    step();
    chk("midrst_first_gnt", 32'(s_gnt), 32'h1);
    reset_n = 1'b0;
    step();
    chk("midrst_gnt_in_reset", 32'(s_gnt), 32'h0);
    chk("midrst_addr_in_reset", 32'(s_addr), 32'h0);
    reset_n = 1'b1;
    req = 4'b0000;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("midrst_no_valid_%0d", i), 32'(s_rdv), 32'h0);
    end
    req = 4'b0011;
    step();
    chk("midrst_ptr_restart", 32'(s_gnt), 32'h1);
    req = 4'b0000;
    step();
    step();
    chk("midrst_return", 32'(s_rdv), 32'h1);
    chk("midrst_return_data", 32'(s_rdd), 32'hCC);
    idle(4);

    // Random traffic
    for (int i = 0; i < 60; i++) begin
      req  = 4'($urandom_range(0, 15));
      rnd  = {$urandom(), $urandom()};
      addr = rnd[39:0];
      step();
    end
    idle(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
